// File: rtl/rf_check_pkg.sv
// Shared definitions for the end-of-test register-file checker.
package rf_check_pkg;

   localparam int unsigned XlenDef = 64;
   localparam int unsigned NregDef = 32;

   // Checker sequencing: arm, wait for halt/timeout, scan, drain pipeline, report.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StWait  = 3'd1,
      StScan  = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } state_e;

endpackage

// File: rtl/rf_check_cmp.sv
// Stage-1 capture of one register/expected pair plus the retire logic that
// classifies it as pass/fail/skip and latches the first mismatch.
module rf_check_cmp
   import rf_check_pkg::*;
#(
   parameter int unsigned XLEN  = XlenDef,
   parameter int unsigned IDX_W = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             vld_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [XLEN-1:0]  got_i,
   input  logic [XLEN-1:0]  exp_i,
   input  logic             care_i,
   output logic [IDX_W:0]   pass_count_o,
   output logic [IDX_W:0]   fail_count_o,
   output logic [IDX_W:0]   skip_count_o,
   output logic             first_fail_vld_o,
   output logic [IDX_W-1:0] first_fail_idx_o,
   output logic [XLEN-1:0]  first_fail_got_o,
   output logic [XLEN-1:0]  first_fail_exp_o
);

   logic             s1_vld_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [XLEN-1:0]  s1_got_q;
   logic [XLEN-1:0]  s1_exp_q;
   logic             s1_care_q;

   logic [IDX_W:0]   pass_q, pass_d;
   logic [IDX_W:0]   fail_q, fail_d;
   logic [IDX_W:0]   skip_q, skip_d;
   logic             ff_vld_q, ff_vld_d;
   logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
   logic [XLEN-1:0]  ff_got_q, ff_got_d;
   logic [XLEN-1:0]  ff_exp_q, ff_exp_d;

   // Stage 1: capture the read-port/ROM pair on every edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_vld_q  <= 1'b0;
         s1_idx_q  <= '0;
         s1_got_q  <= '0;
         s1_exp_q  <= '0;
         s1_care_q <= 1'b0;
      end else begin
         s1_vld_q  <= vld_i;
         s1_idx_q  <= idx_i;
         s1_got_q  <= got_i;
         s1_exp_q  <= exp_i;
         s1_care_q <= care_i;
      end
   end

   // Retire: bump one counter per valid entry; only the first fail is latched.
   always_comb begin
      pass_d   = pass_q;
      fail_d   = fail_q;
      skip_d   = skip_q;
      ff_vld_d = ff_vld_q;
      ff_idx_d = ff_idx_q;
      ff_got_d = ff_got_q;
      ff_exp_d = ff_exp_q;
      if (clear_i) begin
         pass_d   = '0;
         fail_d   = '0;
         skip_d   = '0;
         ff_vld_d = 1'b0;
         ff_idx_d = '0;
         ff_got_d = '0;
         ff_exp_d = '0;
      end else if (s1_vld_q) begin
         if (!s1_care_q) begin
            skip_d = skip_q + 1'b1;
         end else if (s1_got_q == s1_exp_q) begin
            pass_d = pass_q + 1'b1;
         end else begin
            fail_d = fail_q + 1'b1;
            if (!ff_vld_q) begin
               ff_vld_d = 1'b1;
               ff_idx_d = s1_idx_q;
               ff_got_d = s1_got_q;
               ff_exp_d = s1_exp_q;
            end
         end
      end
   end

   // Result registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pass_q   <= '0;
         fail_q   <= '0;
         skip_q   <= '0;
         ff_vld_q <= 1'b0;
         ff_idx_q <= '0;
         ff_got_q <= '0;
         ff_exp_q <= '0;
      end else begin
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         skip_q   <= skip_d;
         ff_vld_q <= ff_vld_d;
         ff_idx_q <= ff_idx_d;
         ff_got_q <= ff_got_d;
         ff_exp_q <= ff_exp_d;
      end
   end

   assign pass_count_o     = pass_q;
   assign fail_count_o     = fail_q;
   assign skip_count_o     = skip_q;
   assign first_fail_vld_o = ff_vld_q;
   assign first_fail_idx_o = ff_idx_q;
   assign first_fail_got_o = ff_got_q;
   assign first_fail_exp_o = ff_exp_q;

endmodule

// File: rtl/rf_result_checker.sv
// End-of-test register-file checker: waits for halt or a cycle budget, then
// scans every register against an expected-value ROM and reports the result.
module rf_result_checker
   import rf_check_pkg::*;
#(
   parameter int unsigned XLEN    = XlenDef,
   parameter int unsigned NREG    = NregDef,
   parameter int unsigned IDX_W   = $clog2(NREG),
   parameter int unsigned TIMEOUT = 150,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             halt_seen_i,
   input  logic [NREG-1:0]  care_mask_i,
   output logic [IDX_W-1:0] rf_rd_addr_o,
   input  logic [XLEN-1:0]  rf_rd_data_i,
   output logic [IDX_W-1:0] exp_addr_o,
   input  logic [XLEN-1:0]  exp_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [IDX_W:0]   pass_count_o,
   output logic [IDX_W:0]   fail_count_o,
   output logic [IDX_W:0]   skip_count_o,
   output logic             first_fail_vld_o,
   output logic [IDX_W-1:0] first_fail_idx_o,
   output logic [XLEN-1:0]  first_fail_got_o,
   output logic [XLEN-1:0]  first_fail_exp_o
);

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IdxLast     = IDX_W'(NREG - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             clear;

   // Next state, WAIT timer and scan index; idx is zero outside SCAN so it
   // can drive the read addresses directly.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = '0;
      clear   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StWait;
               timer_d = '0;
               clear   = 1'b1;
            end
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            if (halt_seen_i || ((TIMEOUT != 0) && (timer_q == TimeoutLast))) begin
               state_d = StScan;
            end
         end
         StScan: begin
            if (idx_q == IdxLast) begin
               state_d = StDrain;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // FSM, timer and index registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         timer_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
      end
   end

   assign rf_rd_addr_o = idx_q;
   assign exp_addr_o   = idx_q;
   assign busy_o       = (state_q == StWait) || (state_q == StScan);
   assign done_o       = (state_q == StDone);
   assign pass_o       = done_o && (fail_count_o == '0);

   rf_check_cmp #(
      .XLEN  (XLEN),
      .IDX_W (IDX_W)
   ) u_cmp (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .clear_i          (clear),
      .vld_i            (state_q == StScan),
      .idx_i            (idx_q),
      .got_i            (rf_rd_data_i),
      .exp_i            (exp_data_i),
      .care_i           (care_mask_i[idx_q]),
      .pass_count_o     (pass_count_o),
      .fail_count_o     (fail_count_o),
      .skip_count_o     (skip_count_o),
      .first_fail_vld_o (first_fail_vld_o),
      .first_fail_idx_o (first_fail_idx_o),
      .first_fail_got_o (first_fail_got_o),
      .first_fail_exp_o (first_fail_exp_o)
   );

endmodule

// File: tb/tb_rf_result_checker.sv
// Bench for rf_result_checker: directed and randomized scans checked against
// an array-based model of the expected counts, first mismatch and timing.
module tb_rf_result_checker;

   localparam int XLEN    = 64;
   localparam int NREG    = 32;
   localparam int IDX_W   = 5;
   localparam int TIMEOUT = 150;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             halt;
   logic [NREG-1:0]  care;
   logic [IDX_W-1:0] rf_rd_addr;
   logic [IDX_W-1:0] exp_addr;
   logic [XLEN-1:0]  rf_rd_data;
   logic [XLEN-1:0]  exp_data;
   logic             busy, done, pass;
   logic [IDX_W:0]   pass_count, fail_count, skip_count;
   logic             ff_vld;
   logic [IDX_W-1:0] ff_idx;
   logic [XLEN-1:0]  ff_got, ff_exp;

   logic [XLEN-1:0]  rf_mem [NREG];
   logic [XLEN-1:0]  rom    [NREG];

   int checks = 0;
   int errors = 0;

   assign rf_rd_data = rf_mem[rf_rd_addr];
   assign exp_data   = rom[exp_addr];

   always #5 clk = ~clk;

   rf_result_checker #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .IDX_W   (IDX_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (16)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .start_i          (start),
      .halt_seen_i      (halt),
      .care_mask_i      (care),
      .rf_rd_addr_o     (rf_rd_addr),
      .rf_rd_data_i     (rf_rd_data),
      .exp_addr_o       (exp_addr),
      .exp_data_i       (exp_data),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .pass_count_o     (pass_count),
      .fail_count_o     (fail_count),
      .skip_count_o     (skip_count),
      .first_fail_vld_o (ff_vld),
      .first_fail_idx_o (ff_idx),
      .first_fail_got_o (ff_got),
      .first_fail_exp_o (ff_exp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_pass"}, 64'(pass), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pcnt"}, 64'(pass_count), 64'd0);
      chk({tag, "_fcnt"}, 64'(fail_count), 64'd0);
      chk({tag, "_scnt"}, 64'(skip_count), 64'd0);
      chk({tag, "_ffvld"}, 64'(ff_vld), 64'd0);
      chk({tag, "_ffidx"}, 64'(ff_idx), 64'd0);
      chk({tag, "_ffgot"}, ff_got, 64'd0);
      chk({tag, "_ffexp"}, ff_exp, 64'd0);
      chk({tag, "_rdaddr"}, 64'(rf_rd_addr), 64'd0);
      chk({tag, "_expaddr"}, 64'(exp_addr), 64'd0);
   endtask

   // Reference: classify every register from the arrays and mask.
   task automatic check_results(input string tag);
      int p = 0, f = 0, s = 0;
      logic fv = 1'b0;
      int fi = 0;
      logic [63:0] fg = '0, fe = '0;
      for (int i = 0; i < NREG; i++) begin
         if (!care[i]) s++;
         else if (rf_mem[i] == rom[i]) p++;
         else begin
            f++;
            if (!fv) begin
               fv = 1'b1; fi = i; fg = rf_mem[i]; fe = rom[i];
            end
         end
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_pass"}, 64'(pass), 64'(f == 0));
      chk({tag, "_pcnt"}, 64'(pass_count), 64'(p));
      chk({tag, "_fcnt"}, 64'(fail_count), 64'(f));
      chk({tag, "_scnt"}, 64'(skip_count), 64'(s));
      chk({tag, "_ffvld"}, 64'(ff_vld), 64'(fv));
      chk({tag, "_ffidx"}, 64'(ff_idx), 64'(fi));
      chk({tag, "_ffgot"}, ff_got, fg);
      chk({tag, "_ffexp"}, ff_exp, fe);
   endtask

   // Arm the checker, raise halt before edge h (0 = never), optionally
   // re-pulse start at edge restart_at; checks busy/address profile and latency.
   task automatic run_scan(input string tag, input int h, input int restart_at);
      int eh;
      int cyc = 0;
      logic busy_ok = 1'b1;
      logic addr_ok = 1'b1;
      eh = (h == 0 || h > TIMEOUT) ? TIMEOUT : h;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_arm_done"}, 64'(done), 64'd0);
      chk({tag, "_arm_busy"}, 64'(busy), 64'd1);
      chk({tag, "_arm_cnt"}, 64'({pass_count, fail_count, skip_count}), 64'd0);
      chk({tag, "_arm_ffvld"}, 64'(ff_vld), 64'd0);
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (h != 0 && n == h) halt = 1'b1;
         if (n == restart_at) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc = n;
         if (busy !== (n <= eh + NREG - 1)) busy_ok = 1'b0;
         if (n >= eh && n <= eh + NREG - 1) begin
            if (rf_rd_addr !== IDX_W'(n - eh) || exp_addr !== IDX_W'(n - eh)) addr_ok = 1'b0;
         end else if (rf_rd_addr !== '0 || exp_addr !== '0) begin
            addr_ok = 1'b0;
         end
         if (done === 1'b1) break;
      end
      halt = 1'b0;
      chk({tag, "_busy_profile"}, 64'(busy_ok), 64'd1);
      chk({tag, "_addr_profile"}, 64'(addr_ok), 64'd1);
      chk({tag, "_latency"}, 64'(cyc), 64'(eh + NREG + 1));
      check_results(tag);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NREG; i++) begin
         rf_mem[i] = {$urandom(), $urandom()};
         rom[i]    = rf_mem[i];
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      halt  = 1'b0;
      care  = '1;
      fill_random();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // Clean ROM, halt at cycle 40.
      run_scan("t1_match", 40, 0);

      // Two mismatches; first at x7.
      rf_mem[7] = 64'd3;
      rom[7]    = 64'd2;
      rom[20]   = rf_mem[20] ^ 64'h8000_0000_0000_0001;
      run_scan("t2_mismatch", $urandom_range(1, 60), 0);

      // No halt: forced scan after TIMEOUT, with an ignored start mid-SCAN.
      run_scan("t3_timeout", 0, TIMEOUT + 5);

      // Halt and timeout firing together.
      run_scan("t3_both", TIMEOUT, 0);

      // Masked-out mismatch at x28.
      fill_random();
      care[28] = 1'b0;
      rom[28]  = ~rf_mem[28];
      run_scan("t4_skip", 12, 0);
      care = '1;

      // Randomized scans.
      for (int r = 0; r < 6; r++) begin
         fill_random();
         care = {$urandom()} | {$urandom()} | {$urandom()};
         for (int i = 0; i < NREG; i++) begin
            if ($urandom_range(0, 5) == 0) rom[i] = rom[i] ^ (64'd1 << $urandom_range(0, 63));
         end
         run_scan($sformatf("rand%0d", r), $urandom_range(1, 120),
                  ($urandom_range(0, 1) == 1) ? 0 : 0 + $urandom_range(125, 150));
      end
      care = '1;

      // Reset while the scan is at idx 10.
      fill_random();
      rom[3] = ~rf_mem[3];
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (n == 5) halt = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("t5_idx10", 64'(rf_rd_addr), 64'd10);
      #2;
      reset = 1'b1;
      #1;
      check_zero("t5_async");
      @(posedge clk);
      #1;
      check_zero("t5_next");
      @(negedge clk);
      reset = 1'b0;
      halt  = 1'b0;
      rom[3] = rf_mem[3];
      run_scan("t5_rescan", 25, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
